dffre_bank_arbiter: RTL and testbench

DFFRE_BANK_ARBITER -- requirements
Module: dffre_bank_arbiter

---
 rtl/dffre_bank_arbiter.sv | 103 ++++++++++
 tb/tb_dffre_bank_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dffre_bank_arbiter.sv
// Register bank with enable/clear per register, shared by N_REQ writers through a
// round-robin arbiter, plus a saturating count of contended cycles.
module dffre_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int N_REG = 4,
    parameter int WIDTH = 8,
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   i_Reset_n,
    input  logic [N_REQ-1:0]       i_Req,
    input  logic [N_REQ*AW-1:0]    i_Addr,
    input  logic [N_REQ*WIDTH-1:0] i_D,
    input  logic [N_REG-1:0]       i_Clr,
    output logic [N_REQ-1:0]       o_Grant,
    output logic [N_REG*WIDTH-1:0] o_Q,
    output logic [7:0]             o_Contention
);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [7:0]             cont_q, cont_d;
    logic [N_REG*WIDTH-1:0] bank_q, bank_d;

    logic                   grant_any;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          cand;
    logic [N_REQ-1:0]       grant;
    logic [AW-1:0]          sel_addr;
    logic [WIDTH-1:0]       sel_data;

    logic [AW-1:0]    addr_arr [N_REQ];
    logic [WIDTH-1:0] data_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = i_Addr[gi*AW +: AW];
            assign data_arr[gi] = i_D[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotating priority search starting at ptr_q; reset suppresses any grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW'((32'(ptr_q) + 32'(i)) % 32'(N_REQ));
            if (!grant_any && i_Req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (!i_Reset_n) begin
            grant_any = 1'b0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            grant[k] = grant_any && (grant_idx == PW'(k));
        end
    end

    assign o_Grant  = grant;
    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    // Clear beats write; an out-of-range address matches no register and is dropped.
    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_bank
            assign bank_d[gi*WIDTH +: WIDTH] =
                i_Clr[gi]                              ? '0 :
                (grant_any && (sel_addr == AW'(gi)))   ? sel_data :
                                                         bank_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        cont_d = cont_q;
        if (($countones(i_Req) >= 2) && (cont_q != 8'hFF)) begin
            cont_d = cont_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ptr_q  <= '0;
            cont_q <= '0;
            bank_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cont_q <= cont_d;
            bank_q <= bank_d;
        end
    end

    assign o_Q          = bank_q;
    assign o_Contention = cont_q;

endmodule

// File: tb/tb_dffre_bank_arbiter.sv
// Directed bench for dffre_bank_arbiter: a reference model pushes expected bank and
// contention values into a scoreboard that is drained after each clock edge.
module tb_dffre_bank_arbiter;

    logic        clk = 1'b0;
    logic        i_Reset_n;
    logic [3:0]  i_Req;
    logic [7:0]  i_Addr;
    logic [31:0] i_D;
    logic [3:0]  i_Clr;
    logic [3:0]  o_Grant;
    logic [31:0] o_Q;
    logic [7:0]  o_Contention;

    always #5 clk = ~clk;

    dffre_bank_arbiter #(.N_REQ(4), .N_REG(4), .WIDTH(8)) dut (
        .clk          (clk),
        .i_Reset_n    (i_Reset_n),
        .i_Req        (i_Req),
        .i_Addr       (i_Addr),
        .i_D          (i_D),
        .i_Clr        (i_Clr),
        .o_Grant      (o_Grant),
        .o_Q          (o_Q),
        .o_Contention (o_Contention)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] regs_m [4];
    int         ptr_m;
    int         cont_m;

    typedef struct packed {
        logic [31:0] q;
        logic [7:0]  cont;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_q();
        return {regs_m[3], regs_m[2], regs_m[1], regs_m[0]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++) regs_m[r] = 8'h00;
        ptr_m  = 0;
        cont_m = 0;
    endtask

    // Called at a falling edge; returns there one cycle later.
    task automatic step(input string tag, input logic [3:0] req, input logic [7:0] addr,
                        input logic [31:0] d, input logic [3:0] clr, output logic [3:0] g_obs);
        logic       gv;
        int         gidx;
        logic [3:0] g_exp;
        exp_t       e;
        i_Req  = req;
        i_Addr = addr;
        i_D    = d;
        i_Clr  = clr;
        #1;
        gv   = 1'b0;
        gidx = 0;
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (ptr_m + i) % 4;
            if (!gv && req[c]) begin
                gv   = 1'b1;
                gidx = c;
            end
        end
        g_exp = gv ? 4'(1 << gidx) : 4'b0000;
        g_obs = o_Grant;
        chk({tag, " grant"}, 32'(o_Grant), 32'(g_exp));
        for (int r = 0; r < 4; r++) begin
            if (clr[r]) regs_m[r] = 8'h00;
            else if (gv && int'(addr[gidx*2 +: 2]) == r) regs_m[r] = d[gidx*8 +: 8];
        end
        if ($countones(req) >= 2 && cont_m < 255) cont_m++;
        if (gv) ptr_m = (gidx + 1) % 4;
        e.q    = model_q();
        e.cont = 8'(cont_m);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " q"}, o_Q, e.q);
        chk({tag, " cont"}, 32'(o_Contention), 32'(e.cont));
        @(negedge clk);
    endtask

    // Reset with all requesters active and data all-ones: nothing may be granted or written.
    task automatic do_reset();
        i_Req     = 4'b1111;
        i_D       = 32'hFFFF_FFFF;
        i_Addr    = 8'b11_10_01_00;
        i_Clr     = 4'b0000;
        i_Reset_n = 1'b0;
        #2;
        model_reset();
        chk("rst q", o_Q, 32'h0);
        chk("rst cont", 32'(o_Contention), 32'h0);
        chk("rst grant", 32'(o_Grant), 32'h0);
        @(posedge clk);
        #1;
        chk("rst held q", o_Q, 32'h0);
        @(negedge clk);
        i_Reset_n = 1'b1;
        i_Req     = 4'b0000;
    endtask

    initial begin
        logic [3:0] g;
        i_Reset_n = 1'b1;
        i_Req     = 4'b0000;
        i_Addr    = 8'h00;
        i_D       = 32'h0;
        i_Clr     = 4'b0000;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester write to register 2
        step("single", 4'b0001, 8'b00_00_00_10, 32'h0000_00A5, 4'b0000, g);
        chk("single grant const", 32'(g), 32'h1);
        chk("single q const", o_Q, 32'h00A5_0000);

        // Round-robin with all four requesting
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("rr", 4'b1111, 8'b11_10_01_00, $urandom, 4'b0000, g);
            chk("rr order", 32'(g), 32'(4'b0001 << (i % 4)));
        end
        chk("rr cont const", 32'(o_Contention), 32'd8);

        // Clear priority over a same-cycle write
        do_reset();
        step("clr pre", 4'b0001, 8'b00_00_00_10, 32'h0000_0077, 4'b0000, g);
        step("clr same", 4'b0010, 8'b00_00_01_00, 32'h0000_3C00, 4'b0010, g);
        chk("clr same q1", 32'(o_Q[15:8]), 32'h00);
        step("clr other", 4'b0010, 8'b00_00_01_00, 32'h0000_3C00, 4'b0100, g);
        chk("clr other q1", 32'(o_Q[15:8]), 32'h3C);
        chk("clr other q2", 32'(o_Q[23:16]), 32'h00);

        // Withdrawn request, then ptr hold while idle
        do_reset();
        step("wd setup", 4'b0001, 8'b00_00_00_11, 32'h0000_0011, 4'b0000, g);
        step("wd both", 4'b0110, 8'b00_01_00_00, 32'h0033_2200, 4'b0000, g);
        chk("wd grant1", 32'(g), 32'h2);
        step("wd drop", 4'b0000, 8'b00_01_00_00, 32'h0033_2200, 4'b0000, g);
        step("wd idle", 4'b0000, 8'h00, 32'h0, 4'b0000, g);
        chk("wd q const", o_Q, 32'h1100_0022);
        step("wd ptr", 4'b1001, 8'b10_00_00_01, 32'h4400_0055, 4'b0000, g);
        chk("wd ptr grant3", 32'(g), 32'h8);

        // Contention saturation with two requesters alternating
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step("sat", 4'b0011, 8'b00_00_11_10, $urandom, 4'b0000, g);
            chk("sat alt", 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        chk("sat cont const", 32'(o_Contention), 32'd255);

        // Asynchronous reset between edges with a grant pending
        do_reset();
        step("ar fill", 4'b0001, 8'b00_00_00_00, 32'h0000_00FF, 4'b0000, g);
        step("ar cont", 4'b0011, 8'b00_00_01_00, 32'h0000_1200, 4'b0000, g);
        i_Req  = 4'b0001;
        i_Addr = 8'b00_00_00_01;
        i_D    = 32'h0000_00EE;
        #2;
        i_Reset_n = 1'b0;
        #1;
        model_reset();
        chk("ar grant", 32'(o_Grant), 32'h0);
        chk("ar q", o_Q, 32'h0);
        chk("ar cont", 32'(o_Contention), 32'h0);
        @(posedge clk);
        #1;
        chk("ar held q", o_Q, 32'h0);
        @(negedge clk);
        i_Reset_n = 1'b1;
        step("ar after", 4'b1111, 8'b11_10_01_00, 32'h0403_0201, 4'b0000, g);
        chk("ar after grant0", 32'(g), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
